// File: rtl/hazard_tracker_pkg.sv
// Shared types and constants for the hazard tracker: register address width,
// the PC register number, and the per-stage control bundle.
package hazard_pkg;

  localparam int REG_W = 4;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic PCSrc;
  } stage_ctl_t;

endpackage

// File: rtl/hazard_tracker_if.sv
// Decode-stage inputs, hazard-unit feedback and tracker outputs, bundled so the
// tracker and its driver see one port; the master side drives the D inputs.
interface hazard_tracker_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 32
);

  logic [REG_W-1:0] RA1D;
  logic [REG_W-1:0] RA2D;
  logic [REG_W-1:0] WA3D;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             PCSrcD;
  logic             CondExE;
  logic             FlushE;
  logic             StallD;
  logic             BranchTakenE;
  logic             CntClr;

  logic             Match_1E_M;
  logic             Match_1E_W;
  logic             Match_2E_M;
  logic             Match_2E_W;
  logic             Match_12D_E;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemtoRegE;
  logic             PCSrcW;
  logic             PCWrPendingF;
  logic [CNT_W-1:0] LdrStallCnt;
  logic [CNT_W-1:0] BrFlushCnt;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD,
           CondExE, FlushE, StallD, BranchTakenE, CntClr,
    input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
           RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF,
           LdrStallCnt, BrFlushCnt
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD,
           CondExE, FlushE, StallD, BranchTakenE, CntClr,
    output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
           RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF,
           LdrStallCnt, BrFlushCnt
  );

endinterface

// File: rtl/hazard_tracker_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_tracker.sv
// Shadows register addresses and write controls through E, M and W so the hazard
// unit can form forwarding, load-use and PC-write decisions; also counts stall/flush events.
module hazard_tracker #(
  parameter int REG_W = hazard_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  hazard_tracker_if.slave bus
);

  import hazard_pkg::*;

  localparam logic [REG_W-1:0] PC_ADDR = REG_W'(PC_REG);

  // R15 reads come from the PC+8 path, so they never count as a dependency.
  function automatic logic fwd_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return (src == dst) && (src != PC_ADDR);
  endfunction

  logic [REG_W-1:0] ra1_e_q, ra1_e_d;
  logic [REG_W-1:0] ra2_e_q, ra2_e_d;
  logic [REG_W-1:0] wa3_e_q, wa3_e_d;
  stage_ctl_t       ctl_e_q, ctl_e_d;
  logic [REG_W-1:0] wa3_m_q, wa3_m_d;
  stage_ctl_t       ctl_m_q, ctl_m_d;
  logic [REG_W-1:0] wa3_w_q, wa3_w_d;
  stage_ctl_t       ctl_w_q, ctl_w_d;
  logic             unused_memtoreg;

  always_comb begin
    // D -> E
    ra1_e_d = bus.RA1D;
    ra2_e_d = bus.RA2D;
    wa3_e_d = bus.WA3D;
    ctl_e_d = '{RegWrite: bus.RegWriteD, MemtoReg: bus.MemtoRegD, PCSrc: bus.PCSrcD};
    if (bus.FlushE) begin
      ra1_e_d = '0;
      ra2_e_d = '0;
      wa3_e_d = '0;
      ctl_e_d = '0;
    end

    // E -> M: a failed condition cancels the writes but the address still moves on
    wa3_m_d          = wa3_e_q;
    ctl_m_d          = '0;
    ctl_m_d.RegWrite = ctl_e_q.RegWrite & bus.CondExE;
    ctl_m_d.MemtoReg = ctl_e_q.MemtoReg;
    ctl_m_d.PCSrc    = ctl_e_q.PCSrc & bus.CondExE;

    // M -> W
    wa3_w_d          = wa3_m_q;
    ctl_w_d          = '0;
    ctl_w_d.RegWrite = ctl_m_q.RegWrite;
    ctl_w_d.PCSrc    = ctl_m_q.PCSrc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ra1_e_q <= '0;
      ra2_e_q <= '0;
      wa3_e_q <= '0;
      ctl_e_q <= '0;
      wa3_m_q <= '0;
      ctl_m_q <= '0;
      wa3_w_q <= '0;
      ctl_w_q <= '0;
    end else begin
      ra1_e_q <= ra1_e_d;
      ra2_e_q <= ra2_e_d;
      wa3_e_q <= wa3_e_d;
      ctl_e_q <= ctl_e_d;
      wa3_m_q <= wa3_m_d;
      ctl_m_q <= ctl_m_d;
      wa3_w_q <= wa3_w_d;
      ctl_w_q <= ctl_w_d;
    end
  end

  assign unused_memtoreg = ctl_m_q.MemtoReg ^ ctl_w_q.MemtoReg;

  // Raw address compares; the hazard unit qualifies them with the write controls.
  assign bus.Match_1E_M  = fwd_match(ra1_e_q, wa3_m_q);
  assign bus.Match_1E_W  = fwd_match(ra1_e_q, wa3_w_q);
  assign bus.Match_2E_M  = fwd_match(ra2_e_q, wa3_m_q);
  assign bus.Match_2E_W  = fwd_match(ra2_e_q, wa3_w_q);
  assign bus.Match_12D_E = fwd_match(bus.RA1D, wa3_e_q) | fwd_match(bus.RA2D, wa3_e_q);

  assign bus.RegWriteM    = ctl_m_q.RegWrite;
  assign bus.RegWriteW    = ctl_w_q.RegWrite;
  assign bus.MemtoRegE    = ctl_e_q.MemtoReg;
  assign bus.PCSrcW       = ctl_w_q.PCSrc;
  assign bus.PCWrPendingF = bus.PCSrcD | ctl_e_q.PCSrc | ctl_m_q.PCSrc;

  sat_counter #(.CNT_W(CNT_W)) u_ldr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.CntClr),
    .inc   (bus.StallD),
    .count (bus.LdrStallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.CntClr),
    .inc   (bus.BranchTakenE),
    .count (bus.BrFlushCnt)
  );

endmodule

// File: tb/tb_hazard_tracker.sv
// Table-driven bench for hazard_tracker with a narrow counter so saturation is reachable.
module tb_hazard_tracker;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_tracker_if #(.REG_W(4), .CNT_W(3)) bus ();

  hazard_tracker #(.REG_W(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ctl bits: {RegWriteD, MemtoRegD, PCSrcD, CondExE, FlushE, StallD, BranchTakenE, CntClr}
  localparam logic [7:0] NONE = 8'h00;
  localparam logic [7:0] RW   = 8'h80;
  localparam logic [7:0] MR   = 8'h40;
  localparam logic [7:0] PC   = 8'h20;
  localparam logic [7:0] CD   = 8'h10;
  localparam logic [7:0] FL   = 8'h08;
  localparam logic [7:0] ST   = 8'h04;
  localparam logic [7:0] BR   = 8'h02;
  localparam logic [7:0] CL   = 8'h01;

  // flags: {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
  //         RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF}
  localparam logic [9:0] ALL  = 10'b11111_00000;
  localparam logic [9:0] CTRL = 10'b00000_11111;

  typedef struct {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic [7:0] ctl;
    logic       rst;
    logic [9:0] flags;
    logic [9:0] fmask;
    logic [2:0] ldr;
    logic [2:0] brc;
    logic       cmask;
  } vec_t;

  typedef struct {
    int         id;
    logic [9:0] flags;
    logic [9:0] fmask;
    logic [2:0] ldr;
    logic [2:0] brc;
    logic       cmask;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int ra1, input int ra2, input int wa3,
                              input logic [7:0] ctl, input logic [9:0] flags,
                              input int ldr, input int brc);
    vec_t v;
    v.ra1   = 4'(ra1);
    v.ra2   = 4'(ra2);
    v.wa3   = 4'(wa3);
    v.ctl   = ctl;
    v.rst   = 1'b0;
    v.flags = flags;
    v.fmask = '1;
    v.ldr   = 3'(ldr);
    v.brc   = 3'(brc);
    v.cmask = 1'b1;
    return v;
  endfunction

  task automatic check_out();
    exp_t       e;
    logic [9:0] af;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got empty queue, required one pending expectation");
      return;
    end
    e  = sb_q.pop_front();
    af = {bus.Match_1E_M, bus.Match_1E_W, bus.Match_2E_M, bus.Match_2E_W, bus.Match_12D_E,
          bus.RegWriteM, bus.RegWriteW, bus.MemtoRegE, bus.PCSrcW, bus.PCWrPendingF};
    n_chk++;
    if ((af & e.fmask) !== (e.flags & e.fmask)) begin
      n_fail++;
      $display("FAIL vec%0d flags: got %b required %b (mask %b)", e.id, af, e.flags, e.fmask);
    end
    if (e.cmask) begin
      n_chk++;
      if ({bus.LdrStallCnt, bus.BrFlushCnt} !== {e.ldr, e.brc}) begin
        n_fail++;
        $display("FAIL vec%0d counters: got ldr=%0d br=%0d required ldr=%0d br=%0d",
                 e.id, bus.LdrStallCnt, bus.BrFlushCnt, e.ldr, e.brc);
      end
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, check mid-cycle, then advance.
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    reset    = v.rst;
    bus.RA1D = v.ra1;
    bus.RA2D = v.ra2;
    bus.WA3D = v.wa3;
    {bus.RegWriteD, bus.MemtoRegD, bus.PCSrcD, bus.CondExE,
     bus.FlushE, bus.StallD, bus.BranchTakenE, bus.CntClr} = v.ctl;
    e.id    = id;
    e.flags = v.flags;
    e.fmask = v.fmask;
    e.ldr   = v.ldr;
    e.brc   = v.brc;
    e.cmask = v.cmask;
    sb_q.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required the test to finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset    = 1'b1;
    bus.RA1D = '0;
    bus.RA2D = '0;
    bus.WA3D = '0;
    {bus.RegWriteD, bus.MemtoRegD, bus.PCSrcD, bus.CondExE,
     bus.FlushE, bus.StallD, bus.BranchTakenE, bus.CntClr} = NONE;
    repeat (3) @(posedge clk);
    #1;

    // idle after reset
    tbl.push_back(mk(0, 0, 0,  NONE, ALL, 0, 0));
    tbl.push_back(mk(0, 0, 0,  NONE, ALL, 0, 0));
    // forward from M, then from W to a second reader
    tbl.push_back(mk(0, 0, 3,  RW | CD, ALL, 0, 0));
    tbl.push_back(mk(3, 0, 0,  CD, ALL, 0, 0));
    tbl.push_back(mk(3, 0, 0,  CD, 10'b10011_10000, 0, 0));
    tbl.push_back(mk(0, 0, 0,  CD, 10'b01101_01000, 0, 0));
    // load-use with flush/stall; the flushed reader must not reach E
    tbl.push_back(mk(0, 0, 5,  RW | MR | CD, ALL, 0, 0));
    tbl.push_back(mk(0, 5, 0,  CD | FL | ST, 10'b11111_00100, 0, 0));
    tbl.push_back(mk(0, 5, 0,  CD, 10'b01011_10000, 1, 0));
    tbl.push_back(mk(0, 0, 0,  CD, 10'b10011_01000, 1, 0));
    // R15 exclusion
    tbl.push_back(mk(0, 0, 15, RW | CD, ALL, 1, 0));
    tbl.push_back(mk(15, 0, 0, CD, 10'b11110_00000, 1, 0));
    tbl.push_back(mk(0, 0, 0,  CD, 10'b00011_10000, 1, 0));
    tbl.push_back(mk(0, 0, 0,  CD, 10'b10101_01000, 1, 0));
    // PC write pending, condition true
    tbl.push_back(mk(0, 0, 0,  PC | CD, 10'b11111_00001, 1, 0));
    tbl.push_back(mk(0, 0, 0,  CD, 10'b11111_00001, 1, 0));
    tbl.push_back(mk(0, 0, 0,  CD, 10'b11111_00001, 1, 0));
    tbl.push_back(mk(0, 0, 0,  CD, 10'b11111_00010, 1, 0));
    // PC write pending, condition false
    tbl.push_back(mk(0, 0, 0,  PC, 10'b11111_00001, 1, 0));
    tbl.push_back(mk(0, 0, 0,  NONE, 10'b11111_00001, 1, 0));
    tbl.push_back(mk(0, 0, 0,  NONE, ALL, 1, 0));
    tbl.push_back(mk(0, 0, 0,  NONE, ALL, 1, 0));
    // branch counter saturation at 7, then clear wins over increment
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(mk(0, 0, 0, BR, ALL, 1, (k > 7) ? 7 : k));
    end
    tbl.push_back(mk(0, 0, 0,  BR | CL, ALL, 1, 7));
    tbl.push_back(mk(0, 0, 0,  NONE, ALL, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Reset in mid-flight overrides flush and the pending counter increments
    v = mk(0, 0, 7, RW | MR | PC | CD | ST | BR, 10'b00000_00001, 0, 0);
    v.fmask = CTRL;
    apply(v, 100);
    v.flags = 10'b00000_00101;
    v.ldr   = 3'd1;
    v.brc   = 3'd1;
    apply(v, 101);
    v.ctl   = v.ctl | FL;
    v.rst   = 1'b1;
    v.flags = 10'b00000_10101;
    v.ldr   = 3'd2;
    v.brc   = 3'd2;
    apply(v, 102);
    apply(mk(0, 0, 0, NONE, ALL, 0, 0), 103);

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d left over, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

- Tracks register addresses and write-control bits of in-flight instructions through the E, M and W stages.
- Produces every match, write-enable and PC-pending input that `hazard` consumes, and reacts to the `FlushE` and `BranchTakenE` values that `hazard` produces.
- Sits beside the datapath pipeline registers.
- Also keeps saturating counters of load-use stalls and branch flushes for performance debug.

## Interface
Parameters:
- REG_W, 4, register address width
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- RA1D, RA2D  in  REG_W  decode-stage source addresses, taken from the IF/ID register outputs
- WA3D  in  REG_W  decode-stage destination address
- RegWriteD, MemtoRegD, PCSrcD  in  1 each  decode-stage controls; PCSrcD marks an instruction that writes the PC
- CondExE  in  1  condition check result of the instruction currently in E
- FlushE, StallD, BranchTakenE  in  1 each  from `hazard` and the datapath
- CntClr  in  1  synchronous clear of both counters
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E  out  1 each  address matches
- RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF  out  1 each
- LdrStallCnt, BrFlushCnt  out  CNT_W  saturating event counters

## Operation
E register, every cycle:
- Captures RA1D, RA2D, WA3D, RegWriteD, MemtoRegD and PCSrcD.
- When FlushE or reset is asserted, E loads a bubble instead: all addresses 0, RegWriteE = MemtoRegE = PCSrcE = 0.
- E never stalls. StallD holds only the IF/ID register, and the D inputs already reflect that.

M register, every cycle:
- Captures WA3E and MemtoRegE.
- RegWriteM = RegWriteE & CondExE; PCSrcM = PCSrcE & CondExE.
- Reset clears it.

W register, every cycle:
- Captures WA3M, RegWriteM and PCSrcM.
- Reset clears it.

Matches (combinational from registered state and D inputs):
- Match_1E_M = (RA1E == WA3M) & (RA1E != 15).
- Match_1E_W = (RA1E == WA3W) & (RA1E != 15).
- Match_2E_M and Match_2E_W are the same with RA2E.
- Match_12D_E = ((RA1D == WA3E) & (RA1D != 15)) | ((RA2D == WA3E) & (RA2D != 15)).
- Register 15 is excluded because PC reads come from the PC+8 path and are never forwarded.
- Matches are raw address compares. `hazard` qualifies them with RegWriteM, RegWriteW and MemtoRegE.

PC-write pending:
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM (combinational).
- PCSrcW is the registered W copy.

Counters:
- LdrStallCnt increments on each cycle with StallD = 1.
- BrFlushCnt increments on each cycle with BranchTakenE = 1.
- Both saturate at 2^CNT_W − 1 and hold there; they never wrap.
- CntClr zeroes both and has priority over increment.
- Reset zeroes both.

## Timing
- Reset values:
  - All registered outputs 0.
  - Counters 0.
  - Combinational outputs after reset with D inputs 0: Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W and Match_12D_E are each 1 (address 0 == 0, not 15). This is harmless because every qualifying control is 0.
- Latency:
  - One clock per stage, D→E→M→W.
  - An instruction's WA3 is visible as WA3E one edge after it sits at the D inputs, WA3M after two edges, WA3W after three.
- FlushE together with a valid D instruction: that instruction is dropped; E holds the bubble for that cycle.
- CondExE = 0: RegWriteM and PCSrcM load 0 while WA3M still loads WA3E.
- Reset asserted mid-operation: it clears E, M, W and the counters at the next edge, and overrides FlushE and CntClr.
- Counter increment is evaluated on the same edge as the event; the new count is visible the next cycle.

## Structure
Shared package `hazard_pkg` holds:
- REG_W.
- Constant PC_REG = 4'd15.
- Packed struct stage_ctl_t {RegWrite, MemtoReg, PCSrc}, used for the E, M and W control bundles.

One sub-module, `sat_counter` (parameter CNT_W; ports clk, reset, clr, inc, count), instantiated twice.

## Test plan
- Reset, then idle with all D inputs 0: RegWriteM, RegWriteW, MemtoRegE, PCSrcW and PCWrPendingF stay 0; both counters stay 0.
- Forward from M:
  - Stimulus: D = {WA3D = 3, RegWriteD = 1}, then D = {RA1D = 3} next cycle, CondExE = 1.
  - Response: one cycle later Match_1E_M = 1 with RegWriteM = 1; the following cycle Match_1E_W = 1 with RegWriteW = 1.
- Load-use:
  - Stimulus: LDR with WA3D = 5, MemtoRegD = 1 enters E, while D holds RA2D = 5.
  - Response: Match_12D_E = 1 and MemtoRegE = 1.
  - Then driving FlushE = 1 and StallD = 1 for one cycle gives MemtoRegE = 0 and RegWriteE = 0 next cycle, and LdrStallCnt = 1.
- R15 exclusion: WA3D = 15 followed by RA1D = 15 → Match_1E_M = 0 and Match_12D_E = 0.
- PC pending:
  - Stimulus: PCSrcD = 1 for one cycle with CondExE = 1.
  - Response: PCWrPendingF = 1 for three consecutive cycles (D, E, M), then PCSrcW = 1 for one cycle.
  - With CondExE = 0 instead: PCWrPendingF drops after the E cycle and PCSrcW stays 0.
- Counter saturation/clear:
  - Stimulus: CNT_W = 3, hold BranchTakenE = 1 for 10 cycles.
  - Response: BrFlushCnt reaches 7 and holds.
  - Then CntClr = 1 together with BranchTakenE = 1 gives BrFlushCnt = 0.
